// File: rtl/spi_pkg.sv
// Shared definitions for the SPI word master: FSM state encoding and
// mode / edge-count helpers.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    CS_GAP   = 3'd4
  } spi_state_e;

  function automatic logic spi_cpol(input int mode);
    return mode[1];
  endfunction

  function automatic logic spi_cpha(input int mode);
    return mode[0];
  endfunction

  // Width able to hold an edge budget of 2*data_w.
  function automatic int spi_edge_w(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCK generator: after i_Start, runs i_Edges half-periods of toggling plus one
// trailing idle half-period, with registered leading/trailing edge strobes.
module spi_sclk_gen #(
  parameter int   CLKS_PER_HALF_BIT = 2,
  parameter int   EDGE_W            = 5,
  parameter logic CPOL              = 1'b0
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Start,
  input  logic [EDGE_W-1:0] i_Edges,
  output logic              o_SPI_Clk,
  output logic              o_Leading_Edge,
  output logic              o_Trailing_Edge,
  output logic [EDGE_W-1:0] o_Edges_Left,
  output logic              o_Done
);

  localparam int HALF_W = $clog2(CLKS_PER_HALF_BIT);

  logic [HALF_W-1:0] r_half_cnt;
  logic              r_active;
  logic              half_end;

  assign half_end = (r_half_cnt == HALF_W'(CLKS_PER_HALF_BIT - 1));
  // Done marks the end of the idle half-period that follows the final edge.
  assign o_Done   = r_active && half_end && (o_Edges_Left == '0);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_half_cnt      <= '0;
      r_active        <= 1'b0;
      o_SPI_Clk       <= CPOL;
      o_Edges_Left    <= '0;
      o_Leading_Edge  <= 1'b0;
      o_Trailing_Edge <= 1'b0;
    end else begin
      o_Leading_Edge  <= 1'b0;
      o_Trailing_Edge <= 1'b0;
      if (i_Start) begin
        r_active     <= 1'b1;
        r_half_cnt   <= '0;
        o_Edges_Left <= i_Edges;
        o_SPI_Clk    <= CPOL;
      end else if (r_active) begin
        if (half_end) begin
          r_half_cnt <= '0;
          if (o_Edges_Left != '0) begin
            o_SPI_Clk       <= ~o_SPI_Clk;
            o_Edges_Left    <= o_Edges_Left - EDGE_W'(1);
            o_Leading_Edge  <= (o_SPI_Clk == CPOL);
            o_Trailing_Edge <= (o_SPI_Clk != CPOL);
          end else begin
            r_active <= 1'b0;
          end
        end else begin
          r_half_cnt <= r_half_cnt + HALF_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/spi_word_master.sv
// SPI master shifting one DATA_W-bit word per valid/ready transfer with CS framing.
// Define SPI_MISO_RX_EN to build the MISO receive path.
module spi_word_master
  import spi_pkg::*;
#(
  parameter int DATA_W            = 12,
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_INACTIVE_CLKS  = 2
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [DATA_W-1:0] i_TX_Word,
  input  logic              i_TX_DV,
  output logic              o_TX_Ready,
  output logic              o_TX_Done,
  output logic              o_SPI_Clk,
  output logic              o_SPI_MOSI,
  output logic              o_SPI_CS_n,
  input  logic              i_SPI_MISO,
  output logic [DATA_W-1:0] o_RX_Word,
  output logic              o_RX_DV,
  output logic [2:0]        o_Dbg_State
);

  // Handshake: a word is taken on any rising i_Clk edge where i_TX_DV and
  // o_TX_Ready are both high; i_TX_DV while o_TX_Ready is low is dropped.

  localparam logic CPOL     = spi_cpol(SPI_MODE);
  localparam logic CPHA     = spi_cpha(SPI_MODE);
  localparam int   EDGE_W   = spi_edge_w(DATA_W);
  localparam int   CNT_MAX  = (CLKS_PER_HALF_BIT > CS_INACTIVE_CLKS) ?
                              CLKS_PER_HALF_BIT : CS_INACTIVE_CLKS;
  localparam int   CNT_W    = $clog2(CNT_MAX);
  localparam int   GAP_LAST = (CS_INACTIVE_CLKS > 1) ? CS_INACTIVE_CLKS - 2 : 0;

  spi_state_e        r_state;
  spi_state_e        state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_tx_sr;
  logic              accept;
  logic              frame_end;
  logic              lead_edge;
  logic              trail_edge;
  logic              sclk_done;
  logic [EDGE_W-1:0] edges_left;

  assign accept      = o_TX_Ready & i_TX_DV;
  assign frame_end   = (r_state == CS_HOLD) && (state_next != CS_HOLD);
  assign o_Dbg_State = r_state;

  spi_sclk_gen #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT),
    .EDGE_W           (EDGE_W),
    .CPOL             (CPOL)
  ) u_sclk_gen (
    .i_Clk          (i_Clk),
    .i_Rst_L        (i_Rst_L),
    .i_Start        (accept),
    .i_Edges        (EDGE_W'(2 * DATA_W)),
    .o_SPI_Clk      (o_SPI_Clk),
    .o_Leading_Edge (lead_edge),
    .o_Trailing_Edge(trail_edge),
    .o_Edges_Left   (edges_left),
    .o_Done         (sclk_done)
  );

  // The IDLE cycle counts as the last gap cycle, so CS_GAP itself runs one
  // cycle short and CS_n stays high exactly CS_INACTIVE_CLKS between frames.
  always_comb begin
    state_next = r_state;
    case (r_state)
      IDLE:     if (accept) state_next = CS_SETUP;
      CS_SETUP: if (r_cnt == CNT_W'(CLKS_PER_HALF_BIT - 1)) state_next = SHIFT;
      SHIFT:    if (sclk_done) state_next = CS_HOLD;
      CS_HOLD:  if (r_cnt == CNT_W'(CLKS_PER_HALF_BIT - 1))
                  state_next = (CS_INACTIVE_CLKS > 1) ? CS_GAP : IDLE;
      CS_GAP:   if (r_cnt == CNT_W'(GAP_LAST)) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_tx_sr    <= '0;
      o_TX_Ready <= 1'b0;
      o_TX_Done  <= 1'b0;
      o_SPI_CS_n <= 1'b1;
      o_SPI_MOSI <= 1'b0;
    end else begin
      r_state    <= state_next;
      r_cnt      <= (state_next != r_state || r_state == IDLE || r_state == SHIFT) ?
                    '0 : r_cnt + CNT_W'(1);
      o_TX_Ready <= (state_next == IDLE);
      o_TX_Done  <= frame_end;
      o_SPI_CS_n <= !(state_next == CS_SETUP || state_next == SHIFT ||
                      state_next == CS_HOLD);
      if (accept) begin
        r_tx_sr    <= i_TX_Word;
        o_SPI_MOSI <= i_TX_Word[DATA_W-1];
      end else if (CPHA) begin
        if (lead_edge) begin
          o_SPI_MOSI <= r_tx_sr[DATA_W-1];
          r_tx_sr    <= {r_tx_sr[DATA_W-2:0], 1'b0};
        end else if (frame_end) begin
          o_SPI_MOSI <= 1'b0;
        end
      end else begin
        // MOSI holds the LSB after the final trailing edge.
        if (trail_edge && edges_left != '0) begin
          o_SPI_MOSI <= r_tx_sr[DATA_W-2];
          r_tx_sr    <= {r_tx_sr[DATA_W-2:0], 1'b0};
        end else if (frame_end) begin
          o_SPI_MOSI <= 1'b0;
        end
      end
    end
  end

`ifdef SPI_MISO_RX_EN
  logic [DATA_W-1:0] r_rx_sr;
  logic              capture;

  assign capture = CPHA ? trail_edge : lead_edge;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rx_sr   <= '0;
      o_RX_Word <= '0;
      o_RX_DV   <= 1'b0;
    end else begin
      o_RX_DV <= frame_end;
      if (capture) r_rx_sr <= {r_rx_sr[DATA_W-2:0], i_SPI_MISO};
      if (frame_end) o_RX_Word <= r_rx_sr;
    end
  end
`else
  logic unused_miso;

  assign unused_miso = i_SPI_MISO;
  assign o_RX_Word   = '0;
  assign o_RX_DV     = 1'b0;
`endif

endmodule
